cb_rd_arbiter: RTL and testbench

CB_RD_ARBITER -- requirements
Module: cb_rd_arbiter

---
 rtl/utils_pkg.sv | 28 ++
 rtl/fifo.sv | 38 +++
 rtl/cb_rd_arbiter.sv | 81 ++++++++
 tb/tb_cb_rd_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// utils_pkg: shared core-bus types, master IDs and read-arbiter FSM states.
package utils_pkg;
  typedef enum logic {MID_INSTR = 1'b0, MID_DATA = 1'b1} master_id_e;
  typedef enum logic [1:0] {ARB_IDLE, ARB_INSTR, ARB_DATA} arb_state_e;
  typedef struct packed {
    logic        rd_addr_valid;
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_ready;
    logic        wr_addr_valid;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic        wr_data_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_resp_ready;
  } s_cb_mosi_t;
  typedef struct packed {
    logic        rd_addr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic        wr_resp_valid;
    logic [1:0]  wr_resp;
  } s_cb_miso_t;
endpackage

// File: rtl/fifo.sv
// fifo: small synchronous FIFO; push while full is accepted only alongside a pop.
module fifo #(
  parameter int SLOTS = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(SLOTS);
  localparam logic [AW:0] FULL_CNT = SLOTS[AW:0];
  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == FULL_CNT;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: rtl/cb_rd_arbiter.sv
// cb_rd_arbiter: arbitrates fetch and LSU reads onto one core-bus slave;
// responses are steered by an in-order queue of issuing master IDs.
module cb_rd_arbiter
  import utils_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit DATA_PRIORITY   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  s_cb_mosi_t instr_cb_mosi_i,
  output s_cb_miso_t instr_cb_miso_o,
  input  s_cb_mosi_t data_cb_mosi_i,
  output s_cb_miso_t data_cb_miso_o,
  output s_cb_mosi_t cb_mosi_o,
  input  s_cb_miso_t cb_miso_i,
  output logic       rsp_err_o
);
  arb_state_e state_q, state_d;
  master_id_e last_grant_q, last_grant_d, gnt, head;
  logic [0:0] head_bits;
  logic gnt_vld, q_full, q_empty, accept, pop, slot_ok, rsp_instr, rsp_data;
  logic unused_instr_wr;
  assign unused_instr_wr = ^{instr_cb_mosi_i.wr_addr_valid, instr_cb_mosi_i.wr_addr,
                             instr_cb_mosi_i.wr_size, instr_cb_mosi_i.wr_data_valid,
                             instr_cb_mosi_i.wr_data, instr_cb_mosi_i.wr_strb,
                             instr_cb_mosi_i.wr_resp_ready};
  // Owner states lock the grant; in idle a tie goes to data unless round-robin says otherwise.
  always_comb begin
    gnt = state_q == ARB_DATA ? MID_DATA
        : state_q == ARB_INSTR ? MID_INSTR
        : (instr_cb_mosi_i.rd_addr_valid && data_cb_mosi_i.rd_addr_valid)
          ? ((DATA_PRIORITY || last_grant_q == MID_INSTR) ? MID_DATA : MID_INSTR)
        : data_cb_mosi_i.rd_addr_valid ? MID_DATA : MID_INSTR;
    gnt_vld      = gnt == MID_DATA ? data_cb_mosi_i.rd_addr_valid : instr_cb_mosi_i.rd_addr_valid;
    slot_ok      = gnt_vld && !q_full;
    accept       = slot_ok && cb_miso_i.rd_addr_ready;
    state_d      = accept ? ARB_IDLE : gnt_vld ? (gnt == MID_DATA ? ARB_DATA : ARB_INSTR) : state_q;
    last_grant_d = accept ? gnt : last_grant_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= MID_INSTR;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  fifo #(.SLOTS(MAX_OUTSTANDING), .WIDTH(1)) u_track (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (gnt),
    .pop_i   (pop),
    .data_o  (head_bits),
    .empty_o (q_empty),
    .full_o  (q_full)
  );
  assign head      = master_id_e'(head_bits);
  assign rsp_instr = cb_miso_i.rd_valid && !q_empty && head == MID_INSTR;
  assign rsp_data  = cb_miso_i.rd_valid && !q_empty && head == MID_DATA;
  assign pop       = cb_miso_i.rd_valid && cb_mosi_o.rd_ready;
  assign rsp_err_o = cb_miso_i.rd_valid && q_empty;
  always_comb begin
    cb_mosi_o               = data_cb_mosi_i;
    cb_mosi_o.rd_addr_valid = slot_ok;
    cb_mosi_o.rd_addr       = !gnt_vld ? '0 : gnt == MID_DATA ? data_cb_mosi_i.rd_addr : instr_cb_mosi_i.rd_addr;
    cb_mosi_o.rd_size       = !gnt_vld ? '0 : gnt == MID_DATA ? data_cb_mosi_i.rd_size : instr_cb_mosi_i.rd_size;
    cb_mosi_o.rd_ready      = !q_empty && (head == MID_DATA ? data_cb_mosi_i.rd_ready : instr_cb_mosi_i.rd_ready);
    data_cb_miso_o               = cb_miso_i;
    data_cb_miso_o.rd_addr_ready = accept && gnt == MID_DATA;
    data_cb_miso_o.rd_valid      = rsp_data;
    data_cb_miso_o.rd_data       = rsp_data ? cb_miso_i.rd_data : '0;
    data_cb_miso_o.rd_resp       = rsp_data ? cb_miso_i.rd_resp : '0;
    instr_cb_miso_o               = '0;
    instr_cb_miso_o.rd_addr_ready = accept && gnt == MID_INSTR;
    instr_cb_miso_o.rd_valid      = rsp_instr;
    instr_cb_miso_o.rd_data       = rsp_instr ? cb_miso_i.rd_data : '0;
    instr_cb_miso_o.rd_resp       = rsp_instr ? cb_miso_i.rd_resp : '0;
  end
endmodule

// File: tb/tb_cb_rd_arbiter.sv
// tb_cb_rd_arbiter: directed checks of grant, queue steering, stall, error pulse and reset.
module tb_cb_rd_arbiter;
  import utils_pkg::*;
  logic clk, rst, err, rr_err;
  s_cb_mosi_t im, dm, so, rr_so;
  s_cb_miso_t sm, im_o, dm_o, rr_im_o, rr_dm_o;
  int checks = 0;
  int failures = 0;

  cb_rd_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .instr_cb_mosi_i(im), .instr_cb_miso_o(im_o),
    .data_cb_mosi_i(dm), .data_cb_miso_o(dm_o),
    .cb_mosi_o(so), .cb_miso_i(sm), .rsp_err_o(err)
  );
  cb_rd_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .instr_cb_mosi_i(im), .instr_cb_miso_o(rr_im_o),
    .data_cb_mosi_i(dm), .data_cb_miso_o(rr_dm_o),
    .cb_mosi_o(rr_so), .cb_miso_i(sm), .rsp_err_o(rr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    im = '0;
    dm = '0;
    sm = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    #1;
    checks++;
    if ({so.rd_addr_valid, so.rd_addr, so.rd_size, so.rd_ready} !== 37'd0) begin
      failures++; $display("FAIL reset_mosi_rd got=%h exp=0", {so.rd_addr_valid, so.rd_addr, so.rd_size, so.rd_ready});
    end
    checks++;
    if ({im_o.rd_valid, im_o.rd_addr_ready, dm_o.rd_valid, dm_o.rd_addr_ready, err} !== 5'd0) begin
      failures++; $display("FAIL reset_miso got=%b exp=00000", {im_o.rd_valid, im_o.rd_addr_ready, dm_o.rd_valid, dm_o.rd_addr_ready, err});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({so.rd_addr_valid, so.rd_addr, im_o.rd_addr_ready, dm_o.rd_addr_ready, err} !== 36'd0) begin
      failures++; $display("FAIL post_reset_idle got=%h exp=0", {so.rd_addr_valid, so.rd_addr, im_o.rd_addr_ready, dm_o.rd_addr_ready, err});
    end
  endtask

  task automatic test_single_instr();
    @(negedge clk);
    im.rd_addr_valid = 1'b1; im.rd_addr = 32'h0000_1000; im.rd_size = 3'd2; im.rd_ready = 1'b1;
    sm.rd_addr_ready = 1'b1;
    #1;
    checks++;
    if ({so.rd_addr_valid, so.rd_addr, so.rd_size} !== {1'b1, 32'h0000_1000, 3'd2}) begin
      failures++; $display("FAIL single_addr got=%h exp=%h", {so.rd_addr_valid, so.rd_addr, so.rd_size}, {1'b1, 32'h0000_1000, 3'd2});
    end
    checks++;
    if ({im_o.rd_addr_ready, dm_o.rd_addr_ready} !== 2'b10) begin
      failures++; $display("FAIL single_ready got=%b exp=10", {im_o.rd_addr_ready, dm_o.rd_addr_ready});
    end
    @(negedge clk);
    im.rd_addr_valid = 1'b0; sm.rd_addr_ready = 1'b0;
    sm.rd_valid = 1'b1; sm.rd_data = 32'hDEAD_BEEF; sm.rd_resp = 2'd0;
    #1;
    checks++;
    if ({im_o.rd_valid, im_o.rd_data, dm_o.rd_valid, dm_o.rd_data, so.rd_ready, err} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL single_rsp got=%h exp=%h", {im_o.rd_valid, im_o.rd_data, dm_o.rd_valid, dm_o.rd_data, so.rd_ready, err},
                           {1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1, 1'b0});
    end
    @(negedge clk);
    sm.rd_valid = 1'b0; sm.rd_data = '0;
    #1;
    checks++;
    if (so.rd_ready !== 1'b0) begin
      failures++; $display("FAIL single_drained rd_ready got=%b exp=0", so.rd_ready);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    im.rd_addr_valid = 1'b1; im.rd_addr = 32'h0000_1004; im.rd_ready = 1'b1;
    dm.rd_addr_valid = 1'b1; dm.rd_addr = 32'h8000_0000; dm.rd_ready = 1'b1;
    sm.rd_addr_ready = 1'b1;
    #1;
    checks++;
    if ({so.rd_addr, dm_o.rd_addr_ready, im_o.rd_addr_ready} !== {32'h8000_0000, 2'b10}) begin
      failures++; $display("FAIL prio_first got=%h exp=%h", {so.rd_addr, dm_o.rd_addr_ready, im_o.rd_addr_ready}, {32'h8000_0000, 2'b10});
    end
    @(negedge clk);
    dm.rd_addr_valid = 1'b0;
    #1;
    checks++;
    if ({so.rd_addr, im_o.rd_addr_ready, dm_o.rd_addr_ready} !== {32'h0000_1004, 2'b10}) begin
      failures++; $display("FAIL prio_second got=%h exp=%h", {so.rd_addr, im_o.rd_addr_ready, dm_o.rd_addr_ready}, {32'h0000_1004, 2'b10});
    end
    @(negedge clk);
    im.rd_addr_valid = 1'b0; sm.rd_addr_ready = 1'b0;
    sm.rd_valid = 1'b1; sm.rd_data = 32'h1111_1111;
    #1;
    checks++;
    if ({dm_o.rd_valid, dm_o.rd_data, im_o.rd_valid} !== {1'b1, 32'h1111_1111, 1'b0}) begin
      failures++; $display("FAIL prio_rsp_data got=%h exp=%h", {dm_o.rd_valid, dm_o.rd_data, im_o.rd_valid}, {1'b1, 32'h1111_1111, 1'b0});
    end
    @(negedge clk);
    sm.rd_data = 32'h2222_2222;
    #1;
    checks++;
    if ({im_o.rd_valid, im_o.rd_data, dm_o.rd_valid} !== {1'b1, 32'h2222_2222, 1'b0}) begin
      failures++; $display("FAIL prio_rsp_instr got=%h exp=%h", {im_o.rd_valid, im_o.rd_data, dm_o.rd_valid}, {1'b1, 32'h2222_2222, 1'b0});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    im.rd_addr_valid = 1'b1; im.rd_addr = 32'h0000_1008;
    dm.rd_addr_valid = 1'b1; dm.rd_addr = 32'h8000_0010;
    sm.rd_addr_ready = 1'b1;
    #1;
    checks++;
    if (rr_so.rd_addr !== 32'h8000_0010) begin
      failures++; $display("FAIL rr_first_tie got=%h exp=80000010", rr_so.rd_addr);
    end
    @(negedge clk);
    dm.rd_addr = 32'h8000_0020;
    #1;
    checks++;
    if ({rr_so.rd_addr, rr_im_o.rd_addr_ready, rr_dm_o.rd_addr_ready} !== {32'h0000_1008, 2'b10}) begin
      failures++; $display("FAIL rr_second_tie got=%h exp=%h", {rr_so.rd_addr, rr_im_o.rd_addr_ready, rr_dm_o.rd_addr_ready}, {32'h0000_1008, 2'b10});
    end
    checks++;
    if (so.rd_addr !== 32'h8000_0020) begin
      failures++; $display("FAIL prio_second_tie got=%h exp=80000020", so.rd_addr);
    end
    do_reset();
  endtask

  task automatic test_stall();
    @(negedge clk);
    dm.rd_addr_valid = 1'b1; dm.rd_addr = 32'h8000_0100; dm.rd_size = 3'd2; dm.rd_ready = 1'b1;
    im.rd_ready = 1'b1;
    #1;
    checks++;
    if ({so.rd_addr_valid, so.rd_addr} !== {1'b1, 32'h8000_0100}) begin
      failures++; $display("FAIL stall_c1 got=%h exp=%h", {so.rd_addr_valid, so.rd_addr}, {1'b1, 32'h8000_0100});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      im.rd_addr_valid = 1'b1; im.rd_addr = 32'h0000_2000;
      #1;
      checks++;
      if ({so.rd_addr, so.rd_size, im_o.rd_addr_ready} !== {32'h8000_0100, 3'd2, 1'b0}) begin
        failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, {so.rd_addr, so.rd_size, im_o.rd_addr_ready}, {32'h8000_0100, 3'd2, 1'b0});
      end
    end
    @(negedge clk);
    sm.rd_addr_ready = 1'b1;
    #1;
    checks++;
    if ({so.rd_addr, dm_o.rd_addr_ready, im_o.rd_addr_ready} !== {32'h8000_0100, 2'b10}) begin
      failures++; $display("FAIL stall_release got=%h exp=%h", {so.rd_addr, dm_o.rd_addr_ready, im_o.rd_addr_ready}, {32'h8000_0100, 2'b10});
    end
    @(negedge clk);
    dm.rd_addr_valid = 1'b0;
    #1;
    checks++;
    if ({so.rd_addr, im_o.rd_addr_ready} !== {32'h0000_2000, 1'b1}) begin
      failures++; $display("FAIL stall_instr_next got=%h exp=%h", {so.rd_addr, im_o.rd_addr_ready}, {32'h0000_2000, 1'b1});
    end
  endtask

  task automatic test_full();
    @(negedge clk);
    im.rd_addr_valid = 1'b0;
    dm.rd_addr_valid = 1'b1; dm.rd_addr = 32'h8000_0200;
    #1;
    checks++;
    if ({so.rd_addr_valid, dm_o.rd_addr_ready, im_o.rd_addr_ready} !== 3'b000) begin
      failures++; $display("FAIL full_stall got=%b exp=000", {so.rd_addr_valid, dm_o.rd_addr_ready, im_o.rd_addr_ready});
    end
    @(negedge clk);
    sm.rd_valid = 1'b1; sm.rd_data = 32'h3333_3333;
    #1;
    checks++;
    if ({so.rd_addr_valid, dm_o.rd_valid, dm_o.rd_data} !== {1'b0, 1'b1, 32'h3333_3333}) begin
      failures++; $display("FAIL full_pop_cycle got=%h exp=%h", {so.rd_addr_valid, dm_o.rd_valid, dm_o.rd_data}, {1'b0, 1'b1, 32'h3333_3333});
    end
    @(negedge clk);
    sm.rd_valid = 1'b0; sm.rd_data = '0;
    #1;
    checks++;
    if ({so.rd_addr_valid, so.rd_addr, dm_o.rd_addr_ready} !== {1'b1, 32'h8000_0200, 1'b1}) begin
      failures++; $display("FAIL full_resume got=%h exp=%h", {so.rd_addr_valid, so.rd_addr, dm_o.rd_addr_ready}, {1'b1, 32'h8000_0200, 1'b1});
    end
    @(negedge clk);
    dm.rd_addr_valid = 1'b0; sm.rd_addr_ready = 1'b0;
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    #1;
    checks++;
    if (so.rd_ready !== 1'b1) begin
      failures++; $display("FAIL inflight_pending rd_ready got=%b exp=1", so.rd_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({so.rd_addr_valid, so.rd_addr, so.rd_ready, err} !== 35'd0) begin
      failures++; $display("FAIL inflight_reset got=%h exp=0", {so.rd_addr_valid, so.rd_addr, so.rd_ready, err});
    end
    @(negedge clk);
    rst = 1'b0;
    sm.rd_valid = 1'b1; sm.rd_data = 32'h4444_4444;
    #1;
    checks++;
    if ({err, im_o.rd_valid, dm_o.rd_valid, so.rd_ready} !== 4'b1000) begin
      failures++; $display("FAIL late_rsp_err got=%b exp=1000", {err, im_o.rd_valid, dm_o.rd_valid, so.rd_ready});
    end
    @(negedge clk);
    sm.rd_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_one_cycle got=%b exp=0", err);
    end
  endtask

  task automatic test_empty_rsp();
    @(negedge clk);
    im.rd_ready = 1'b1; dm.rd_ready = 1'b1;
    sm.rd_valid = 1'b1; sm.rd_data = 32'h5555_5555;
    #1;
    checks++;
    if ({err, im_o.rd_valid, dm_o.rd_valid, im_o.rd_data, dm_o.rd_data} !== {3'b100, 64'd0}) begin
      failures++; $display("FAIL empty_rsp got=%h exp=%h", {err, im_o.rd_valid, dm_o.rd_valid, im_o.rd_data, dm_o.rd_data}, {3'b100, 64'd0});
    end
    @(negedge clk);
    sm.rd_valid = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL empty_rsp_clear got=%b exp=0", err);
    end
  endtask

  task automatic test_write_pass();
    @(negedge clk);
    idle_inputs();
    dm.wr_addr_valid = 1'b1; dm.wr_addr = 32'h0000_0040; dm.wr_data = 32'hCAFE_0001; dm.wr_strb = 4'hF;
    im.wr_addr_valid = 1'b1; im.wr_addr = 32'h0000_0080;
    sm.wr_resp_valid = 1'b1; sm.wr_resp = 2'd2; sm.wr_addr_ready = 1'b1;
    #1;
    checks++;
    if ({so.wr_addr_valid, so.wr_addr, so.wr_data, so.wr_strb} !== {1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'hF}) begin
      failures++; $display("FAIL wr_mosi got=%h exp=%h", {so.wr_addr_valid, so.wr_addr, so.wr_data, so.wr_strb}, {1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'hF});
    end
    checks++;
    if ({dm_o.wr_resp_valid, dm_o.wr_resp, dm_o.wr_addr_ready, im_o.wr_resp_valid, im_o.wr_resp, im_o.wr_addr_ready} !== 8'b1_10_1_0_00_0) begin
      failures++; $display("FAIL wr_miso got=%b exp=11010000", {dm_o.wr_resp_valid, dm_o.wr_resp, dm_o.wr_addr_ready, im_o.wr_resp_valid, im_o.wr_resp, im_o.wr_addr_ready});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_instr();
    test_priority();
    test_round_robin();
    test_stall();
    test_full();
    test_reset_inflight();
    test_empty_rsp();
    test_write_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
